// File: rtl/cam_pattern_gen.sv
// ============================================================================
// Module   : cam_pattern_gen
// Brief    : Camera-interface stimulus source: FVAL/LVAL/DVAL timing plus
//            CH_NUM pixel channels in ramp / horizontal / vertical / constant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_pattern_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CH_NUM      = 2,
    parameter int HTOTAL      = 360,
    parameter int VTOTAL      = 492,
    parameter int HACTIVE     = 320,
    parameter int VACTIVE     = 480,
    parameter int CH_OFFSET   = 16,
    parameter int FCNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic [1:0]                    i_mode,
    input  logic [FCNT_WIDTH-1:0]         i_frames,
    input  logic [PIXEL_WIDTH-1:0]        i_const_val,
    output logic                          o_busy,
    output logic                          o_frame_end,
    output logic                          o_fval,
    output logic                          o_lval,
    output logic                          o_dval,
    output logic [CH_NUM*PIXEL_WIDTH-1:0] o_data,
    output logic [FCNT_WIDTH-1:0]         o_frame_num
);

    localparam int HW = (HTOTAL > 1) ? $clog2(HTOTAL) : 1;
    localparam int VW = (VTOTAL > 1) ? $clog2(VTOTAL) : 1;

    localparam logic [HW-1:0] C_H_LAST  = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] C_V_LAST  = VW'(VTOTAL - 1);
    localparam logic [HW-1:0] C_H_START = HW'(HTOTAL - HACTIVE);
    localparam logic [VW-1:0] C_V_START = VW'(VTOTAL - VACTIVE);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [1:0] M_RAMP  = 2'd0;
    localparam logic [1:0] M_HORIZ = 2'd1;
    localparam logic [1:0] M_VERT  = 2'd2;
    localparam logic [1:0] M_CONST = 2'd3;

    // Control state
    logic [0:0]             state_q,  state_d;
    logic [HW-1:0]          h_q,      h_d;
    logic [VW-1:0]          v_q,      v_d;
    logic [PIXEL_WIDTH-1:0] ramp_q,   ramp_d;
    logic [1:0]             mode_q,   mode_d;
    logic [FCNT_WIDTH-1:0]  frames_q, frames_d;
    logic                   stop_q,   stop_d;
    logic [FCNT_WIDTH-1:0]  fnum_q,   fnum_d;

    // Registered outputs
    logic                          busy_q,  busy_d;
    logic                          fend_q,  fend_d;
    logic                          fval_q,  fval_d;
    logic                          lval_q,  lval_d;
    logic                          dval_q,  dval_d;
    logic [CH_NUM*PIXEL_WIDTH-1:0] data_q,  data_d;

    logic                  w_at_end;
    logic                  w_last;
    logic [FCNT_WIDTH-1:0] w_fnum_inc;
    logic [HW-1:0]         w_x;
    logic [VW-1:0]         w_y;

    assign w_at_end   = (h_q == C_H_LAST) && (v_q == C_V_LAST);
    assign w_fnum_inc = fnum_q + FCNT_WIDTH'(1);
    // A STOP sampled on the frame's last edge still makes this the final frame.
    assign w_last     = stop_q || i_stop ||
                        ((frames_q != '0) && (w_fnum_inc == frames_q));

    // Active-area indices of the position about to be presented.
    assign w_x = h_d - C_H_START;
    assign w_y = v_d - C_V_START;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            ramp_q   <= '0;
            mode_q   <= '0;
            frames_q <= '0;
            stop_q   <= 1'b0;
            fnum_q   <= '0;
            busy_q   <= 1'b0;
            fend_q   <= 1'b0;
            fval_q   <= 1'b0;
            lval_q   <= 1'b0;
            dval_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            ramp_q   <= ramp_d;
            mode_q   <= mode_d;
            frames_q <= frames_d;
            stop_q   <= stop_d;
            fnum_q   <= fnum_d;
            busy_q   <= busy_d;
            fend_q   <= fend_d;
            fval_q   <= fval_d;
            lval_q   <= lval_d;
            dval_q   <= dval_d;
            data_q   <= data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        ramp_d   = ramp_q;
        mode_d   = mode_q;
        frames_d = frames_q;
        stop_d   = stop_q;
        fnum_d   = fnum_q;

        case (state_q)
            S_IDLE: begin
                // START wins over a simultaneous STOP: the stop flag starts clear.
                if (i_start) begin
                    state_d  = S_RUN;
                    h_d      = '0;
                    v_d      = '0;
                    ramp_d   = '0;
                    mode_d   = i_mode;
                    frames_d = i_frames;
                    stop_d   = 1'b0;
                    fnum_d   = '0;
                end
            end
            S_RUN: begin
                stop_d = stop_q | i_stop;
                ramp_d = ramp_q + PIXEL_WIDTH'(1);
                if (w_at_end) begin
                    fnum_d = w_fnum_inc;
                    h_d    = '0;
                    v_d    = '0;
                    if (w_last) begin
                        state_d = S_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        mode_d = i_mode;
                    end
                end else if (h_q == C_H_LAST) begin
                    h_d = '0;
                    v_d = v_q + VW'(1);
                end else begin
                    h_d = h_q + HW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: computed for the next position so every output is a flop
    // ------------------------------------------------------------------------
    always_comb begin
        busy_d = 1'b0;
        fend_d = 1'b0;
        fval_d = 1'b0;
        lval_d = 1'b0;
        dval_d = 1'b0;
        data_d = '0;

        if (state_d == S_RUN) begin
            busy_d = 1'b1;
            fval_d = (v_d >= C_V_START);
            lval_d = (h_d >= C_H_START);
            dval_d = fval_d & lval_d;
            fend_d = (h_d == C_H_LAST) && (v_d == C_V_LAST);
            for (int c = 0; c < CH_NUM; c++) begin
                case (mode_d)
                    M_RAMP: begin
                        data_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] =
                            ramp_d + PIXEL_WIDTH'(c * CH_OFFSET);
                    end
                    M_HORIZ: begin
                        if (dval_d) begin
                            data_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] =
                                PIXEL_WIDTH'(w_x) + PIXEL_WIDTH'(c * CH_OFFSET);
                        end
                    end
                    M_VERT: begin
                        if (dval_d) begin
                            data_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] =
                                PIXEL_WIDTH'(w_y) + PIXEL_WIDTH'(c * CH_OFFSET);
                        end
                    end
                    M_CONST: begin
                        if (dval_d) begin
                            data_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] = i_const_val;
                        end
                    end
                    default: begin
                        data_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
                    end
                endcase
            end
        end
    end

    assign o_busy      = busy_q;
    assign o_frame_end = fend_q;
    assign o_fval      = fval_q;
    assign o_lval      = lval_q;
    assign o_dval      = dval_q;
    assign o_data      = data_q;
    assign o_frame_num = fnum_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_pattern_gen.sv
// ============================================================================
// Module   : tb_cam_pattern_gen
// Brief    : Scoreboard bench for cam_pattern_gen on a small 8x4 raster.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_pattern_gen;

    localparam int PW   = 8;
    localparam int CH   = 3;
    localparam int HT   = 8;
    localparam int VT   = 4;
    localparam int HA   = 4;
    localparam int VA   = 2;
    localparam int OFS  = 16;
    localparam int FW   = 8;
    localparam int FLEN = HT * VT;

    // Observation word: {busy, frame_end, fval, lval, dval, data, frame_num}
    typedef logic [5+CH*PW+FW-1:0] obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic [FW-1:0] i_frames = '0;
    logic [PW-1:0] i_const_val = '0;
    logic          o_busy;
    logic          o_frame_end;
    logic          o_fval;
    logic          o_lval;
    logic          o_dval;
    logic [CH*PW-1:0] o_data;
    logic [FW-1:0] o_frame_num;

    obs_t exp_q[$];
    obs_t got;
    obs_t exp_v;
    int   n_checks = 0;
    int   n_fail = 0;

    cam_pattern_gen #(
        .PIXEL_WIDTH(PW), .CH_NUM(CH), .HTOTAL(HT), .VTOTAL(VT),
        .HACTIVE(HA), .VACTIVE(VA), .CH_OFFSET(OFS), .FCNT_WIDTH(FW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
        .i_mode(i_mode), .i_frames(i_frames), .i_const_val(i_const_val),
        .o_busy(o_busy), .o_frame_end(o_frame_end), .o_fval(o_fval),
        .o_lval(o_lval), .o_dval(o_dval), .o_data(o_data),
        .o_frame_num(o_frame_num)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "time limit");
    end

    // Expected output stream of one full frame, in raster order.
    task automatic push_frame(input int mode, input int cv, input int l0, input int fn);
        logic [CH*PW-1:0] d;
        int  val;
        logic fv, lv, dv, fe;
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                fv = (v >= VT - VA);
                lv = (h >= HT - HA);
                dv = fv & lv;
                fe = (v == VT - 1) && (h == HT - 1);
                for (int c = 0; c < CH; c++) begin
                    case (mode)
                        0:       val = l0 + v * HT + h + c * OFS;
                        1:       val = dv ? (h - (HT - HA) + c * OFS) : 0;
                        2:       val = dv ? (v - (VT - VA) + c * OFS) : 0;
                        default: val = dv ? cv : 0;
                    endcase
                    d[c*PW +: PW] = val[PW-1:0];
                end
                exp_q.push_back({1'b1, fe, fv, lv, dv, d, fn[FW-1:0]});
            end
        end
    endtask

    task automatic push_idle(input int fn, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(obs_t'(fn[FW-1:0]));
    endtask

    task automatic test_reset();
        i_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
            n_checks++;
            if (got !== obs_t'(0)) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %h required 0", k, got);
            end
        end
        rst = 1'b0;
        i_start = 1'b0;
        @(posedge clk); #1;
        got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
        n_checks++;
        if (got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_idle: got %h required 0", got);
        end
    endtask

    task automatic test_horizontal();
        push_frame(1, 0, 0, 0);
        push_frame(1, 0, 0, 1);
        push_idle(2, 2);
        i_start = 1'b1; i_mode = 2'd1; i_frames = 8'd2;
        for (int k = 0; k < 2 * FLEN + 2; k++) begin
            @(posedge clk); #1;
            got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL horizontal cycle %0d: got %h, no expected entry", k, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL horizontal cycle %0d: got %h required %h", k, got, exp_v);
                end
            end
            i_start = 1'b0;
        end
    endtask

    // Ten frames so the 8-bit ramp wraps and must carry across frame boundaries.
    task automatic test_ramp();
        for (int f = 0; f < 10; f++) push_frame(0, 0, f * FLEN, f);
        push_idle(10, 1);
        i_start = 1'b1; i_mode = 2'd0; i_frames = 8'd10;
        for (int k = 0; k < 10 * FLEN + 1; k++) begin
            @(posedge clk); #1;
            got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ramp cycle %0d: got %h, no expected entry", k, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL ramp cycle %0d: got %h required %h", k, got, exp_v);
                end
            end
            i_start = 1'b0;
        end
    endtask

    task automatic test_stop();
        // Unbounded run, STOP pulsed inside the second frame, then held in IDLE.
        push_frame(2, 0, 0, 0);
        push_frame(2, 0, 0, 1);
        push_idle(2, 6);
        i_start = 1'b1; i_mode = 2'd2; i_frames = 8'd0;
        for (int k = 0; k < 2 * FLEN + 6; k++) begin
            @(posedge clk); #1;
            got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stop_mid cycle %0d: got %h, no expected entry", k, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL stop_mid cycle %0d: got %h required %h", k, got, exp_v);
                end
            end
            i_start = 1'b0;
            if (k == FLEN + 8)  i_stop = 1'b1;
            if (k == FLEN + 9)  i_stop = 1'b0;
            if (k == 2 * FLEN)  i_stop = 1'b1;
        end
        i_stop = 1'b0;
        // STOP present only on the edge leaving the last position of frame 0.
        push_frame(1, 0, 0, 0);
        push_idle(1, 2);
        i_start = 1'b1; i_mode = 2'd1; i_frames = 8'd0;
        for (int k = 0; k < FLEN + 2; k++) begin
            @(posedge clk); #1;
            got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stop_last cycle %0d: got %h, no expected entry", k, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL stop_last cycle %0d: got %h required %h", k, got, exp_v);
                end
            end
            i_start = 1'b0;
            i_stop  = (k == FLEN - 1);
        end
        i_stop = 1'b0;
    endtask

    task automatic test_mode_switch();
        i_const_val = 8'hA5;
        push_frame(2, 'hA5, 0, 0);
        push_frame(3, 'hA5, 0, 1);
        push_frame(3, 'hA5, 0, 2);
        push_idle(3, 1);
        i_start = 1'b1; i_mode = 2'd2; i_frames = 8'd3;
        for (int k = 0; k < 3 * FLEN + 1; k++) begin
            @(posedge clk); #1;
            got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mode_switch cycle %0d: got %h, no expected entry", k, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL mode_switch cycle %0d: got %h required %h", k, got, exp_v);
                end
            end
            i_start = 1'b0;
            if (k == 10) i_mode = 2'd3;
        end
    endtask

    // START+STOP together, START/FRAMES changes mid-run, restart in first IDLE cycle.
    task automatic test_back_to_back();
        push_frame(1, 0, 0, 0);
        push_frame(1, 0, 0, 1);
        push_idle(2, 1);
        push_frame(2, 0, 0, 0);
        push_idle(1, 1);
        i_start = 1'b1; i_stop = 1'b1; i_mode = 2'd1; i_frames = 8'd2;
        for (int k = 0; k < 3 * FLEN + 2; k++) begin
            @(posedge clk); #1;
            got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h, no expected entry", k, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL back_to_back cycle %0d: got %h required %h", k, got, exp_v);
                end
            end
            i_start = 1'b0;
            i_stop  = 1'b0;
            if (k == 5) begin
                i_start = 1'b1; i_frames = 8'd5;
            end
            if (k == 2 * FLEN) begin
                i_start = 1'b1; i_frames = 8'd1; i_mode = 2'd2;
            end
        end
    endtask

    task automatic test_async_reset();
        push_frame(0, 0, 0, 0);
        push_frame(0, 0, FLEN, 1);
        i_start = 1'b1; i_mode = 2'd0; i_frames = 8'd0;
        for (int k = 0; k < FLEN + 13; k++) begin
            @(posedge clk); #1;
            got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: got %h, no expected entry", k, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL pre_reset cycle %0d: got %h required %h", k, got, exp_v);
                end
            end
            i_start = 1'b0;
        end
        exp_q.delete();
        // Mid-line reset must clear outputs before the next clock edge.
        #2 rst = 1'b1;
        #1;
        got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
        n_checks++;
        if (got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 0", got);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push_frame(0, 0, 0, 0);
        push_idle(1, 1);
        i_start = 1'b1; i_mode = 2'd0; i_frames = 8'd1;
        for (int k = 0; k < FLEN + 1; k++) begin
            @(posedge clk); #1;
            got = {o_busy, o_frame_end, o_fval, o_lval, o_dval, o_data, o_frame_num};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: got %h, no expected entry", k, got);
            end else begin
                exp_v = exp_q.pop_front();
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL post_reset cycle %0d: got %h required %h", k, got, exp_v);
                end
            end
            i_start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_ramp();
        test_stop();
        test_mode_switch();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
